// File: rtl/l1_trig_intercon.sv
// Wishbone 1-to-4 bridge into the L1 trigger register space (thresh/control/agc/bq).
// Optional downstream timeout: define L1_INTERCON_TIMEOUT_EN.
module l1_trig_intercon #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] DISABLED_DATA  = 32'h0000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rstn_i,
  input  logic        clock_enabled_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [14:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        wb_rty_o,
  output logic [31:0] wb_dat_o,
  output logic        thresh_cyc_o,
  output logic        thresh_stb_o,
  output logic        thresh_we_o,
  output logic [12:0] thresh_adr_o,
  output logic [31:0] thresh_dat_o,
  output logic [3:0]  thresh_sel_o,
  input  logic        thresh_ack_i,
  input  logic        thresh_err_i,
  input  logic        thresh_rty_i,
  input  logic [31:0] thresh_dat_i,
  output logic        control_cyc_o,
  output logic        control_stb_o,
  output logic        control_we_o,
  output logic [12:0] control_adr_o,
  output logic [31:0] control_dat_o,
  output logic [3:0]  control_sel_o,
  input  logic        control_ack_i,
  input  logic        control_err_i,
  input  logic        control_rty_i,
  input  logic [31:0] control_dat_i,
  output logic        agc_cyc_o,
  output logic        agc_stb_o,
  output logic        agc_we_o,
  output logic [12:0] agc_adr_o,
  output logic [31:0] agc_dat_o,
  output logic [3:0]  agc_sel_o,
  input  logic        agc_ack_i,
  input  logic        agc_err_i,
  input  logic        agc_rty_i,
  input  logic [31:0] agc_dat_i,
  output logic        bq_cyc_o,
  output logic        bq_stb_o,
  output logic        bq_we_o,
  output logic [12:0] bq_adr_o,
  output logic [31:0] bq_dat_o,
  output logic [3:0]  bq_sel_o,
  input  logic        bq_ack_i,
  input  logic        bq_err_i,
  input  logic        bq_rty_i,
  input  logic [31:0] bq_dat_i
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  typedef enum logic [1:0] {R_ACK, R_ERR, R_RTY} resp_t;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t      state_q, state_d;
  resp_t       resp_q, resp_d;
  logic [1:0]  tgt_q, tgt_d;
  logic        we_q, we_d;
  logic [12:0] adr_q, adr_d;
  logic [31:0] wdat_q, wdat_d;
  logic [3:0]  sel_q, sel_d;
  logic        cyc_q, cyc_d;
  logic [31:0] rdat_q, rdat_d;
  logic        drop_q, drop_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic        rty_q, rty_d;

`ifdef L1_INTERCON_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                      $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  logic        s_ack, s_err, s_rty;
  logic [31:0] s_dat;

  // Only the port that owns the current access may terminate it
  always_comb begin
    s_ack = 1'b0;
    s_err = 1'b0;
    s_rty = 1'b0;
    s_dat = '0;
    unique case (tgt_q)
      2'd0: {s_ack, s_err, s_rty, s_dat} =
              {thresh_ack_i, thresh_err_i, thresh_rty_i, thresh_dat_i};
      2'd1: {s_ack, s_err, s_rty, s_dat} =
              {control_ack_i, control_err_i, control_rty_i, control_dat_i};
      2'd2: {s_ack, s_err, s_rty, s_dat} =
              {agc_ack_i, agc_err_i, agc_rty_i, agc_dat_i};
      default: {s_ack, s_err, s_rty, s_dat} =
              {bq_ack_i, bq_err_i, bq_rty_i, bq_dat_i};
    endcase
  end

  always_comb begin
    state_d = state_q;
    resp_d  = resp_q;
    tgt_d   = tgt_q;
    we_d    = we_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    sel_d   = sel_q;
    cyc_d   = cyc_q;
    rdat_d  = rdat_q;
    drop_d  = drop_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rty_d   = 1'b0;
`ifdef L1_INTERCON_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        drop_d = 1'b0;
`ifdef L1_INTERCON_TIMEOUT_EN
        cnt_d  = '0;
`endif
        if (wb_cyc_i && wb_stb_i) begin
          tgt_d  = wb_adr_i[14:13];
          adr_d  = wb_adr_i[12:0];
          wdat_d = wb_dat_i;
          we_d   = wb_we_i;
          sel_d  = wb_sel_i;
          if (clock_enabled_i) begin
            cyc_d   = 1'b1;
            state_d = ACCESS;
          end else begin
            rdat_d  = DISABLED_DATA;
            resp_d  = R_ACK;
            state_d = DONE;
          end
        end
      end
      ACCESS: begin
        if (!wb_cyc_i) drop_d = 1'b1;
        if (s_err || s_rty || s_ack) begin
          cyc_d   = 1'b0;
          rdat_d  = s_dat;
          resp_d  = s_err ? R_ERR : (s_rty ? R_RTY : R_ACK);
          state_d = DONE;
        end
`ifdef L1_INTERCON_TIMEOUT_EN
        else if (cnt_q == LAST) begin
          cyc_d   = 1'b0;
          rdat_d  = '1;
          resp_d  = R_ERR;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
        // An abandoned cycle completes downstream but is never terminated
        if (wb_cyc_i && !drop_q) begin
          ack_d = (resp_q == R_ACK);
          err_d = (resp_q == R_ERR);
          rty_d = (resp_q == R_RTY);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      state_q <= IDLE;
      resp_q  <= R_ACK;
      tgt_q   <= '0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      wdat_q  <= '0;
      sel_q   <= '0;
      cyc_q   <= 1'b0;
      rdat_q  <= '0;
      drop_q  <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rty_q   <= 1'b0;
`ifdef L1_INTERCON_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      resp_q  <= resp_d;
      tgt_q   <= tgt_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      sel_q   <= sel_d;
      cyc_q   <= cyc_d;
      rdat_q  <= rdat_d;
      drop_q  <= drop_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rty_q   <= rty_d;
`ifdef L1_INTERCON_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
  assign wb_rty_o = rty_q;
  assign wb_dat_o = rdat_q;

  assign thresh_cyc_o  = cyc_q & (tgt_q == 2'd0);
  assign thresh_stb_o  = thresh_cyc_o;
  assign thresh_we_o   = thresh_cyc_o & we_q;
  assign thresh_adr_o  = adr_q;
  assign thresh_dat_o  = wdat_q;
  assign thresh_sel_o  = sel_q;

  assign control_cyc_o = cyc_q & (tgt_q == 2'd1);
  assign control_stb_o = control_cyc_o;
  assign control_we_o  = control_cyc_o & we_q;
  assign control_adr_o = adr_q;
  assign control_dat_o = wdat_q;
  assign control_sel_o = sel_q;

  assign agc_cyc_o     = cyc_q & (tgt_q == 2'd2);
  assign agc_stb_o     = agc_cyc_o;
  assign agc_we_o      = agc_cyc_o & we_q;
  assign agc_adr_o     = adr_q;
  assign agc_dat_o     = wdat_q;
  assign agc_sel_o     = sel_q;

  assign bq_cyc_o      = cyc_q & (tgt_q == 2'd3);
  assign bq_stb_o      = bq_cyc_o;
  assign bq_we_o       = bq_cyc_o & we_q;
  assign bq_adr_o      = adr_q;
  assign bq_dat_o      = wdat_q;
  assign bq_sel_o      = sel_q;

endmodule

// File: tb/tb_l1_trig_intercon.sv
// Scoreboard bench for l1_trig_intercon: directed accesses to all four ports,
// disabled clock, response priority, abandon, back-to-back and async reset.
module tb_l1_trig_intercon;

  localparam int TMO = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we = 1'b0;
  logic [14:0] adr = '0;
  logic [31:0] wdat = '0;
  logic [3:0]  sel = '0;
  logic        ack, err, rty;
  logic [31:0] rdat;

  logic [3:0]  s_cyc, s_stb, s_we;
  logic [12:0] s_adr [4];
  logic [31:0] s_dato [4];
  logic [3:0]  s_sel [4];
  logic [3:0]  s_ack, s_err, s_rty;
  logic [31:0] rd [4];
  logic [2:0]  cfg [4];
  logic [3:0]  pulse = '0;
  logic [3:0]  mute = '0;
  logic [3:0]  resp_prev = '0;

  int          tests = 0;
  int          fails = 0;
  logic [34:0] sb [$];

  always #5 clk = ~clk;

  l1_trig_intercon #(.TIMEOUT_CYCLES(TMO), .DISABLED_DATA(32'h0)) dut (
    .wb_clk_i(clk), .wb_rstn_i(rst_n), .clock_enabled_i(en),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
    .wb_ack_o(ack), .wb_err_o(err), .wb_rty_o(rty), .wb_dat_o(rdat),
    .thresh_cyc_o(s_cyc[0]), .thresh_stb_o(s_stb[0]), .thresh_we_o(s_we[0]),
    .thresh_adr_o(s_adr[0]), .thresh_dat_o(s_dato[0]), .thresh_sel_o(s_sel[0]),
    .thresh_ack_i(s_ack[0]), .thresh_err_i(s_err[0]), .thresh_rty_i(s_rty[0]),
    .thresh_dat_i(rd[0]),
    .control_cyc_o(s_cyc[1]), .control_stb_o(s_stb[1]), .control_we_o(s_we[1]),
    .control_adr_o(s_adr[1]), .control_dat_o(s_dato[1]), .control_sel_o(s_sel[1]),
    .control_ack_i(s_ack[1]), .control_err_i(s_err[1]), .control_rty_i(s_rty[1]),
    .control_dat_i(rd[1]),
    .agc_cyc_o(s_cyc[2]), .agc_stb_o(s_stb[2]), .agc_we_o(s_we[2]),
    .agc_adr_o(s_adr[2]), .agc_dat_o(s_dato[2]), .agc_sel_o(s_sel[2]),
    .agc_ack_i(s_ack[2]), .agc_err_i(s_err[2]), .agc_rty_i(s_rty[2]),
    .agc_dat_i(rd[2]),
    .bq_cyc_o(s_cyc[3]), .bq_stb_o(s_stb[3]), .bq_we_o(s_we[3]),
    .bq_adr_o(s_adr[3]), .bq_dat_o(s_dato[3]), .bq_sel_o(s_sel[3]),
    .bq_ack_i(s_ack[3]), .bq_err_i(s_err[3]), .bq_rty_i(s_rty[3]),
    .bq_dat_i(rd[3])
  );

  // Slaves answer one cycle after seeing cyc/stb, with cfg = {err,rty,ack}
  always @(posedge clk)
    for (int i = 0; i < 4; i++)
      pulse[i] <= s_cyc[i] & s_stb[i] & ~pulse[i] & ~mute[i];

  assign s_ack = pulse & {cfg[3][0], cfg[2][0], cfg[1][0], cfg[0][0]};
  assign s_rty = pulse & {cfg[3][1], cfg[2][1], cfg[1][1], cfg[0][1]};
  assign s_err = pulse & {cfg[3][2], cfg[2][2], cfg[1][2], cfg[0][2]};

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [34:0] e;
    if (rst_n && (ack || err || rty)) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL stray_term: got %b expected none", {err, rty, ack});
      end else begin
        e = sb.pop_front();
        chk("term_kind", {29'd0, err, rty, ack}, {29'd0, e[34:32]});
        chk("term_data", rdat, e[31:0]);
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++)
      if (rst_n && resp_prev[i]) chk("cyc_drop", {31'd0, s_cyc[i]}, 32'd0);
    resp_prev <= s_ack | s_err | s_rty;
  end

  task automatic do_access(input logic [14:0] a, input logic [31:0] d,
                           input logic w, input logic e, input logic drop_e,
                           input logic [2:0] k, input logic [31:0] x,
                           input int lat);
    int n;
    logic seen;
    logic [1:0] t;
    t = a[14:13];
    @(negedge clk);
    en = e; cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d;
    sel = w ? 4'h5 : 4'hF;
    sb.push_back({k, x});
    n = 0;
    seen = 1'b0;
    while (!seen && n < TMO + 50) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        chk("cyc_vec", {28'd0, s_cyc}, e ? (32'd1 << t) : 32'd0);
        if (e) begin
          chk("stb_vec", {28'd0, s_stb}, 32'd1 << t);
          chk("we_vec", {28'd0, s_we}, w ? (32'd1 << t) : 32'd0);
          chk("adr", {19'd0, s_adr[t]}, {19'd0, a[12:0]});
          chk("wdat", s_dato[t], d);
          chk("sel", {28'd0, s_sel[t]}, {28'd0, sel});
        end
        if (drop_e) en = 1'b0;
      end
      seen = ack | err | rty;
    end
    chk("latency", n, lat);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int acks;
    rd[0] = 32'hBABEFACE; rd[1] = 32'h12345678;
    rd[2] = 32'h8BADF00D; rd[3] = 32'hCAFEBABE;
    for (int i = 0; i < 4; i++) cfg[i] = 3'b001;
    repeat (3) @(negedge clk);
    chk("rst_term", {29'd0, err, rty, ack}, 32'd0);
    chk("rst_rdat", rdat, 32'd0);
    chk("rst_cyc", {28'd0, s_cyc}, 32'd0);
    rst_n = 1'b1;

    do_access(15'h0000, 32'h0, 1'b0, 1'b0, 1'b0, 3'b001, 32'h0, 2);
    do_access(15'h0000, 32'h0, 1'b0, 1'b1, 1'b0, 3'b001, 32'hBABEFACE, 4);
    do_access(15'h2008, 32'h00C0FFEE, 1'b1, 1'b1, 1'b0, 3'b001, 32'h12345678, 4);
    do_access(15'h4000, 32'h0, 1'b0, 1'b1, 1'b1, 3'b001, 32'h8BADF00D, 4);
    do_access(15'h4000, 32'hCAB00D1E, 1'b1, 1'b1, 1'b0, 3'b001, 32'h8BADF00D, 4);
    do_access(15'h6000, 32'h0, 1'b0, 1'b1, 1'b0, 3'b001, 32'hCAFEBABE, 4);
    do_access(15'h6000, 32'hBEEFBABE, 1'b1, 1'b1, 1'b0, 3'b001, 32'hCAFEBABE, 4);

    cfg[1] = 3'b101;
    do_access(15'h2010, 32'h0, 1'b0, 1'b1, 1'b0, 3'b100, 32'h12345678, 4);
    cfg[1] = 3'b001;
    cfg[2] = 3'b011;
    do_access(15'h4020, 32'h0, 1'b0, 1'b1, 1'b0, 3'b010, 32'h8BADF00D, 4);
    cfg[2] = 3'b001;

    // Abandon: master drops cyc while the thresh access is in flight
    @(negedge clk);
    en = 1'b1; cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 15'h0004; sel = 4'hF;
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    repeat (6) @(negedge clk);
    chk("abandon_idle", {28'd0, s_cyc}, 32'd0);
    do_access(15'h0008, 32'h0, 1'b0, 1'b1, 1'b0, 3'b001, 32'hBABEFACE, 4);

    // Back-to-back with the clock disabled: request held across the ack
    @(negedge clk);
    en = 1'b0; cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 15'h6004;
    sb.push_back({3'b001, 32'h0});
    sb.push_back({3'b001, 32'h0});
    n = 0;
    acks = 0;
    while (acks < 2 && n < 20) begin
      @(negedge clk);
      n++;
      if (ack) acks++;
    end
    chk("b2b_acks", acks, 2);
    chk("b2b_cycles", n, 4);
    cyc = 1'b0; stb = 1'b0;

    // Async reset while a write to a silent slave is in ACCESS
    do_access(15'h2000, 32'h0, 1'b0, 1'b1, 1'b0, 3'b001, 32'h12345678, 4);
    mute[0] = 1'b1;
    @(negedge clk);
    en = 1'b1; cyc = 1'b1; stb = 1'b1; we = 1'b1;
    adr = 15'h0123; wdat = 32'h5A5A5A5A; sel = 4'hF;
    @(negedge clk);
    chk("rst_pre_cyc", {28'd0, s_cyc}, 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rstm_cyc", {28'd0, s_cyc}, 32'd0);
    chk("rstm_stb", {28'd0, s_stb}, 32'd0);
    chk("rstm_we", {28'd0, s_we}, 32'd0);
    chk("rstm_adr", {19'd0, s_adr[0]}, 32'd0);
    chk("rstm_dat", s_dato[0], 32'd0);
    chk("rstm_sel", {28'd0, s_sel[0]}, 32'd0);
    chk("rstm_rdat", rdat, 32'd0);
    chk("rstm_term", {29'd0, err, rty, ack}, 32'd0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mute[0] = 1'b0;
    do_access(15'h0010, 32'h0, 1'b0, 1'b1, 1'b0, 3'b001, 32'hBABEFACE, 4);

`ifdef L1_INTERCON_TIMEOUT_EN
    mute[2] = 1'b1;
    do_access(15'h4010, 32'h0, 1'b0, 1'b1, 1'b0, 3'b100, 32'hFFFFFFFF, TMO + 2);
    mute[2] = 1'b0;
`endif

    repeat (5) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
